ddr_reset_requester: RTL

//  Upstream driver of ddr_reset_sequencer. Turns an asynchronous user reset request (button/soft bit)

---
 rtl/ddr_rst_pkg.sv | 31 +++
 rtl/req_debounce.sv | 61 ++++++
 rtl/ddr_reset_requester.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ddr_rst_pkg.sv
// Shared definitions for the DDR reset requester: FSM state encoding and
// helpers that size the settle window and the shared phase counter.
package ddr_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_QUIESCE   = 3'd1,
    ST_RESET     = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  localparam int RETRY_W = 2;

  // Cycles the sequencer needs after its reset before init_done is meaningful.
  function automatic int settle_cycles(input int seq_cnt_bit_width);
    settle_cycles = 3 * (1 << seq_cnt_bit_width) + 2;
  endfunction

  // Width of the one counter that times quiesce, pulse, settle and init_done waits.
  function automatic int cnt_width(input int timeout_bits, input int settle_len, input int pulse_len);
    int w;
    w = timeout_bits;
    if ($clog2(settle_len) > w) w = $clog2(settle_len);
    if ($clog2(pulse_len) > w)  w = $clog2(pulse_len);
    if (w < 1) w = 1;
    cnt_width = w;
  endfunction

endpackage

// File: rtl/req_debounce.sv
// Request front end: brings the asynchronous user request into clk,
// demands a stable-high run before accepting it, and emits a single-cycle
// pulse on the accepted rising edge. A held request never fires again.
module req_debounce
  import ddr_rst_pkg::*;
#(
  parameter int DEBOUNCE_BIT_WIDTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_req,
  output logic req
);

  localparam logic [DEBOUNCE_BIT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DEBOUNCE_BIT_WIDTH-1:0] CNT_ONE = DEBOUNCE_BIT_WIDTH'(1'b1);

  logic                          sync1_r;
  logic                          sync2_r;
  logic [DEBOUNCE_BIT_WIDTH-1:0] cnt_r;
  logic                          deb_r;
  logic                          deb_dly_r;

  // Two-flop synchroniser for the asynchronous request level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= rst_req;
      sync2_r <= sync1_r;
    end
  end

  // Run-length debounce: any low sample restarts; 2**N highs in a row accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      deb_r <= 1'b0;
    end else if (!sync2_r) begin
      cnt_r <= '0;
      deb_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      deb_r <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_dly_r <= 1'b0;
    end else begin
      deb_dly_r <= deb_r;
    end
  end

  assign req = deb_r & ~deb_dly_r;

endmodule

// File: rtl/ddr_reset_requester.sv
// DDR reset requester: turns a debounced user request into a traffic-safe
// reset of the DDR sequencer (drain traffic, pulse reset, wait out the
// sequence, confirm init_done with timeout and bounded retry). After block
// reset it only confirms the configuration-driven power-on init.
module ddr_reset_requester
  import ddr_rst_pkg::*;
#(
  parameter int DEBOUNCE_BIT_WIDTH = 3,
  parameter int RST_PULSE_CYCLES   = 4,
  parameter int SEQ_CNT_BIT_WIDTH  = 8,
  parameter int TIMEOUT_BIT_WIDTH  = 16,
  parameter int MAX_RETRY          = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_req,
  input  logic       quiesce_ack,
  input  logic       ddr_init_done,
  output logic       quiesce_req,
  output logic       ddr_rst,
  output logic       ready,
  output logic       busy,
  output logic       fail,
  output logic       quiesce_forced,
  output logic [1:0] retry_cnt
);

  localparam int SETTLE_LEN   = settle_cycles(SEQ_CNT_BIT_WIDTH);
  localparam int TIMEOUT_LAST = (1 << TIMEOUT_BIT_WIDTH) - 2;
  localparam int CNT_W        = cnt_width(TIMEOUT_BIT_WIDTH, SETTLE_LEN, RST_PULSE_CYCLES);

  // Counter values seen in the last cycle of each timed phase (counter is 0 on entry).
  localparam logic [CNT_W-1:0]   TIMEOUT_HIT = CNT_W'(TIMEOUT_LAST);
  localparam logic [CNT_W-1:0]   PULSE_HIT   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_HIT  = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1'b1);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1'b1);

  state_e             state_r;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               forced_nxt;
  logic               timeout_s;
  logic               req_s;
  logic               quiesce_req_nxt;
  logic               ddr_rst_nxt;
  logic               ready_nxt;
  logic               busy_nxt;
  logic               fail_nxt;

  req_debounce #(
    .DEBOUNCE_BIT_WIDTH (DEBOUNCE_BIT_WIDTH)
  ) u_req_debounce (
    .clk     (clk),
    .rst     (rst),
    .rst_req (rst_req),
    .req     (req_s)
  );

  assign timeout_s = (cnt_r == TIMEOUT_HIT);

  // Next state, retry/forced bookkeeping, phase counter and decoded outputs.
  always_comb begin
    state_nxt  = state_r;
    retry_nxt  = retry_cnt;
    forced_nxt = quiesce_forced;
    cnt_nxt    = '0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt = ST_QUIESCE;
          retry_nxt = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_QUIESCE: begin
        if (quiesce_ack) begin
          state_nxt = ST_RESET;
        end else if (timeout_s) begin
          state_nxt  = ST_RESET;
          forced_nxt = 1'b1;
        end else begin
          state_nxt = ST_QUIESCE;
        end
      end
      ST_RESET: begin
        if (cnt_r == PULSE_HIT) begin
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_RESET;
        end
      end
      ST_SETTLE: begin
        // init_done is not trustworthy while the sequencer is still starting up.
        if (cnt_r == SETTLE_HIT) begin
          state_nxt = ST_WAIT_DONE;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_WAIT_DONE: begin
        if (ddr_init_done) begin
          state_nxt = ST_IDLE;
        end else if (timeout_s) begin
          if (retry_cnt < RETRY_LIM) begin
            state_nxt = ST_RESET;
            retry_nxt = (retry_cnt == RETRY_SAT) ? RETRY_SAT : (retry_cnt + RETRY_ONE);
          end else begin
            state_nxt = ST_FAIL;
          end
        end else begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_FAIL: begin
        if (req_s) begin
          state_nxt = ST_QUIESCE;
          retry_nxt = '0;
        end else begin
          state_nxt = ST_FAIL;
        end
      end
      default: begin
        state_nxt = ST_WAIT_DONE;
        retry_nxt = '0;
      end
    endcase

    if ((state_nxt != state_r) || (state_r == ST_IDLE) || (state_r == ST_FAIL)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_r + CNT_ONE;
    end

    quiesce_req_nxt = (state_nxt != ST_IDLE);
    ddr_rst_nxt     = (state_nxt == ST_RESET);
    ready_nxt       = (state_nxt == ST_IDLE);
    busy_nxt        = (state_nxt != ST_IDLE) && (state_nxt != ST_FAIL);
    fail_nxt        = (state_nxt == ST_FAIL);
  end

  // State, counter and all outputs registered; reset lands in WAIT_DONE with traffic held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_WAIT_DONE;
      cnt_r          <= '0;
      quiesce_req    <= 1'b1;
      ddr_rst        <= 1'b0;
      ready          <= 1'b0;
      busy           <= 1'b1;
      fail           <= 1'b0;
      quiesce_forced <= 1'b0;
      retry_cnt      <= 2'd0;
    end else begin
      state_r        <= state_nxt;
      cnt_r          <= cnt_nxt;
      quiesce_req    <= quiesce_req_nxt;
      ddr_rst        <= ddr_rst_nxt;
      ready          <= ready_nxt;
      busy           <= busy_nxt;
      fail           <= fail_nxt;
      quiesce_forced <= forced_nxt;
      retry_cnt      <= retry_nxt;
    end
  end

endmodule
